// File: rtl/axis_pcp_vector_checker.sv
// In-line AXI4-Stream PCP vector framing checker.
// Every beat passes through one output register unchanged. Each channel has its own
// framing FSM, and the checker reports good vectors and framing errors one cycle after
// a beat is accepted.
// Handshake: a beat moves on a port in any cycle where tvalid && tready are both high at
// the rising edge. While tvalid is high and no transfer has happened, the source holds
// the beat stable.
module axis_pcp_vector_checker #(
  parameter int DATA_WIDTH = 512,
  parameter int NUM_CH = 4,
  parameter int VEC_LEN = 12,
  parameter int MARKER_WIDTH = 16,
  parameter logic [MARKER_WIDTH-1:0] MARKER = 'd2718,
  parameter int CNT_WIDTH = 16,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [CH_W-1:0]             s_axis_tdest,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [CH_W-1:0]             m_axis_tdest,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  input  logic                        clear,
  output logic                        vec_done,
  output logic [CH_W-1:0]             vec_ch,
  output logic                        err_valid,
  output logic [2:0]                  err_code,
  output logic [NUM_CH*CNT_WIDTH-1:0] vec_count,
  output logic [CNT_WIDTH-1:0]        err_count
);

  typedef enum logic [1:0] {EXP_DATA, EXP_MARK, RESYNC} ch_state_e;

  localparam logic [2:0] ERR_NONE         = 3'd0;
  localparam logic [2:0] ERR_BAD_INDEX    = 3'd1;
  localparam logic [2:0] ERR_BAD_MARKER   = 3'd2;
  localparam logic [2:0] ERR_EARLY_LAST   = 3'd3;
  localparam logic [2:0] ERR_MISSING_LAST = 3'd4;
  localparam logic [2:0] ERR_BAD_CH       = 3'd5;
  localparam logic [7:0] VL = 8'(VEC_LEN);

  logic [DATA_WIDTH-1:0] m_data_q;
  logic [CH_W-1:0]       m_dest_q;
  logic                  m_last_q, m_valid_q;

  // Per-channel FSM state; st_q doubles as the debug view of every channel FSM.
  ch_state_e  st_q   [NUM_CH];
  ch_state_e  st_d   [NUM_CH];
  logic [7:0] elem_q [NUM_CH];
  logic [7:0] elem_d [NUM_CH];

  logic                 vec_done_q, err_valid_q;
  logic [2:0]           err_code_q, code_d;
  logic [CH_W-1:0]      vec_ch_q, ch_d;
  logic                 done_d, err_d;
  logic [CNT_WIDTH-1:0] vec_cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] err_cnt_q;

  logic acc, in_range;

  assign s_axis_tready = !m_valid_q || m_axis_tready;
  assign acc           = s_axis_tvalid && s_axis_tready;
  assign in_range      = (32'(s_axis_tdest) < NUM_CH);

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tdest  = m_dest_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tvalid = m_valid_q;
  assign vec_done      = vec_done_q;
  assign err_valid     = err_valid_q;
  assign err_code      = err_code_q;
  assign vec_ch        = vec_ch_q;
  assign err_count     = err_cnt_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
    assign vec_count[g*CNT_WIDTH +: CNT_WIDTH] = vec_cnt_q[g];
  end

  // Output stage: load on every accepted beat, empty once taken with nothing new behind it.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_data_q  <= '0;
      m_dest_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else if (acc) begin
      m_data_q  <= s_axis_tdata;
      m_dest_q  <= s_axis_tdest;
      m_last_q  <= s_axis_tlast;
      m_valid_q <= 1'b1;
    end else if (m_axis_tready) begin
      m_valid_q <= 1'b0;
    end
  end

  // Framing check of the accepted beat against its channel FSM (at most one error per beat).
  always_comb begin
    logic [2:0] ec;
    st_d   = st_q;
    elem_d = elem_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    code_d = err_code_q;
    ch_d   = vec_ch_q;
    ec     = ERR_NONE;
    if (acc && !in_range) begin
      err_d  = 1'b1;
      code_d = ERR_BAD_CH;
      ch_d   = s_axis_tdest;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (acc && in_range && (s_axis_tdest == CH_W'(c))) begin
        ec = ERR_NONE;
        case (st_q[c])
          EXP_DATA: begin
            if (s_axis_tdata[7:0] != elem_q[c]) ec = ERR_BAD_INDEX;
            else if (s_axis_tlast)              ec = ERR_EARLY_LAST;
            else                                st_d[c] = EXP_MARK;
          end
          EXP_MARK: begin
            if (s_axis_tdata[MARKER_WIDTH-1:0] != MARKER) begin
              ec = ERR_BAD_MARKER;
            end else if (elem_q[c] < VL) begin
              if (s_axis_tlast) begin
                ec = ERR_EARLY_LAST;
              end else begin
                elem_d[c] = elem_q[c] + 8'd1;
                st_d[c]   = EXP_DATA;
              end
            end else if (!s_axis_tlast) begin
              ec = ERR_MISSING_LAST;
            end else begin
              done_d    = 1'b1;
              ch_d      = s_axis_tdest;
              elem_d[c] = 8'd1;
              st_d[c]   = EXP_DATA;
            end
          end
          default: begin
            if (s_axis_tlast) begin
              st_d[c]   = EXP_DATA;
              elem_d[c] = 8'd1;
            end
          end
        endcase
        if (ec != ERR_NONE) begin
          err_d  = 1'b1;
          code_d = ec;
          ch_d   = s_axis_tdest;
          if (s_axis_tlast || (ec == ERR_MISSING_LAST)) begin
            st_d[c]   = EXP_DATA;
            elem_d[c] = 8'd1;
          end else begin
            st_d[c] = RESYNC;
          end
        end
      end
    end
  end

  // Channel FSM and status pulse registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]   <= EXP_DATA;
        elem_q[c] <= 8'd1;
      end
      vec_done_q  <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      vec_ch_q    <= '0;
    end else begin
      st_q        <= st_d;
      elem_q      <= elem_d;
      vec_done_q  <= done_d;
      err_valid_q <= err_d;
      err_code_q  <= code_d;
      vec_ch_q    <= ch_d;
    end
  end

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge aclk) begin
    if (areset || clear) begin
      for (int c = 0; c < NUM_CH; c++) vec_cnt_q[c] <= '0;
      err_cnt_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (done_d && (s_axis_tdest == CH_W'(c)) && (vec_cnt_q[c] != '1))
          vec_cnt_q[c] <= vec_cnt_q[c] + 1'b1;
      end
      if (err_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_pcp_vector_checker.sv
// Directed bench for axis_pcp_vector_checker: 5 channels so tdest 5/6 are out of range,
// 8-bit counters so saturation is reachable in a few hundred beats.
module tb_axis_pcp_vector_checker;

  localparam int DW = 64;
  localparam int NCH = 5;
  localparam int CHW = 3;
  localparam int CW = 8;
  localparam logic [15:0] MARK = 16'd2718;

  logic clk, rst;
  logic [DW-1:0] s_tdata, m_tdata;
  logic [CHW-1:0] s_tdest, m_tdest, vec_ch;
  logic s_tlast, s_tvalid, s_tready, m_tlast, m_tvalid, m_tready;
  logic clear, vec_done, err_valid;
  logic [2:0] err_code;
  logic [NCH*CW-1:0] vec_count;
  logic [CW-1:0] err_count;

  int checks = 0;
  int failures = 0;
  logic bp_en = 1'b0;
  int bp_cnt = 0;

  logic [DW+CHW:0] exp_q[$];
  logic [6:0] got_ev[$];
  logic [6:0] exp_ev[$];

  axis_pcp_vector_checker #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .VEC_LEN(12), .MARKER_WIDTH(16),
    .MARKER(MARK), .CNT_WIDTH(CW)
  ) dut (
    .aclk(clk), .areset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tdest(s_tdest), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tdest(m_tdest), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .clear(clear), .vec_done(vec_done), .vec_ch(vec_ch), .err_valid(err_valid),
    .err_code(err_code), .vec_count(vec_count), .err_count(err_count)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog obs=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Downstream backpressure: 2 cycles low, 6 high
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      m_tready = (bp_cnt >= 2);
      bp_cnt = (bp_cnt + 1) % 8;
    end
  end

  // Output scoreboard and status event capture
  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) check("out_spurious", 80'(m_tvalid), 80'(0));
        else check("out_beat", 80'({m_tdest, m_tlast, m_tdata}), 80'(exp_q.pop_front()));
      end
      if (vec_done) got_ev.push_back({1'b1, vec_ch, 3'd0});
      if (err_valid) got_ev.push_back({1'b0, vec_ch, err_code});
    end
  end

  function automatic logic [DW-1:0] data_beat(input int idx);
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    d[7:0] = 8'(idx);
    return d;
  endfunction

  function automatic logic [DW-1:0] mark_beat(input logic [15:0] m);
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    d[15:0] = m;
    return d;
  endfunction

  function automatic logic [CW-1:0] vc(input int c);
    return vec_count[c*CW +: CW];
  endfunction

  task automatic send(input logic [CHW-1:0] dest, input logic [DW-1:0] data, input logic last);
    int waits;
    logic ok;
    s_tvalid = 1'b1; s_tdata = data; s_tdest = dest; s_tlast = last;
    waits = 0;
    do begin
      @(negedge clk); ok = s_tready;
      @(posedge clk); #1;
      waits++;
    end while (!ok && waits < 1000);
    check("send_ready", 80'(ok), 80'(1));
    if (ok) exp_q.push_back({dest, last, data});
    s_tvalid = 1'b0;
  endtask

  task automatic pair(input logic [CHW-1:0] ch, input int idx, input logic [15:0] m, input logic last);
    send(ch, data_beat(idx), 1'b0);
    send(ch, mark_beat(m), last);
  endtask

  task automatic good_vec(input logic [CHW-1:0] ch);
    for (int i = 1; i <= 12; i++) pair(ch, i, MARK, i == 12);
  endtask

  task automatic exp_done(input logic [CHW-1:0] ch);
    exp_ev.push_back({1'b1, ch, 3'd0});
  endtask

  task automatic exp_err(input logic [CHW-1:0] ch, input logic [2:0] code);
    exp_ev.push_back({1'b0, ch, code});
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_events(input string tag);
    int n;
    drain();
    check($sformatf("%s_ev_count", tag), 80'(got_ev.size()), 80'(exp_ev.size()));
    n = (got_ev.size() < exp_ev.size()) ? got_ev.size() : exp_ev.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_ev%0d", tag, i), 80'(got_ev[i]), 80'(exp_ev[i]));
    got_ev.delete();
    exp_ev.delete();
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tdest = '0; s_tlast = 1'b0;
    m_tready = 1'b1; clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_m_tvalid", 80'(m_tvalid), 80'(0));
    check("rst_m_tdata", 80'({m_tdest, m_tlast, m_tdata}), 80'(0));
    check("rst_s_tready", 80'(s_tready), 80'(1));
    check("rst_pulses", 80'({vec_done, err_valid, err_code, vec_ch}), 80'(0));
    check("rst_vec_count", 80'(vec_count), 80'(0));
    check("rst_err_count", 80'(err_count), 80'(0));
    @(posedge clk); #1;

    // 1: three good vectors on ch0
    for (int v = 0; v < 3; v++) begin good_vec(0); exp_done(0); end
    check_events("t1");
    check("t1_vec0", 80'(vc(0)), 80'(3));
    check("t1_err", 80'(err_count), 80'(0));

    // 2: backpressure 2 low / 6 high
    bp_en = 1'b1;
    for (int v = 0; v < 2; v++) begin good_vec(1); exp_done(1); end
    check_events("t2");
    bp_en = 1'b0; m_tready = 1'b1;
    drain();
    check("t2_out_drained", 80'(exp_q.size()), 80'(0));
    check("t2_vec1", 80'(vc(1)), 80'(2));

    // 3: bad marker at elem 5, resync, then a good vector
    for (int i = 1; i <= 4; i++) pair(2, i, MARK, 1'b0);
    pair(2, 5, 16'h009E, 1'b0);
    exp_err(2, 3'd2);
    for (int i = 6; i <= 12; i++) pair(2, i, MARK, i == 12);
    good_vec(2); exp_done(2);
    check_events("t3");
    check("t3_vec2", 80'(vc(2)), 80'(1));
    check("t3_err", 80'(err_count), 80'(1));

    // 4: early last at elem 7, missing last at elem 12, bad index, recovery
    for (int i = 1; i <= 6; i++) pair(0, i, MARK, 1'b0);
    pair(0, 7, MARK, 1'b1); exp_err(0, 3'd3);
    for (int i = 1; i <= 11; i++) pair(0, i, MARK, 1'b0);
    pair(0, 12, MARK, 1'b0); exp_err(0, 3'd4);
    good_vec(0); exp_done(0);
    send(1, data_beat(3), 1'b0); exp_err(1, 3'd1);
    send(1, mark_beat(MARK), 1'b1);
    good_vec(1); exp_done(1);
    check_events("t4");
    check("t4_vec0", 80'(vc(0)), 80'(4));
    check("t4_vec1", 80'(vc(1)), 80'(3));
    check("t4_err", 80'(err_count), 80'(4));

    // 5: interleave ch0/ch3 with an out-of-range tdest beat
    for (int i = 1; i <= 12; i++) begin
      send(0, data_beat(i), 1'b0);
      send(3, data_beat(i), 1'b0);
      if (i == 6) begin send(5, data_beat(i), 1'b0); exp_err(5, 3'd5); end
      send(0, mark_beat(MARK), i == 12);
      send(3, mark_beat(MARK), i == 12);
    end
    exp_done(0); exp_done(3);
    check_events("t5");
    check("t5_vec0", 80'(vc(0)), 80'(5));
    check("t5_vec3", 80'(vc(3)), 80'(1));
    check("t5_err", 80'(err_count), 80'(5));

    // 6a: clear held across the completing beat and its vec_done cycle
    for (int i = 1; i <= 11; i++) pair(3, i, MARK, 1'b0);
    send(3, data_beat(12), 1'b0);
    clear = 1'b1;
    send(3, mark_beat(MARK), 1'b1);
    @(posedge clk); #1 clear = 1'b0;
    exp_done(3);
    check_events("t6a");
    check("t6a_vec_all", 80'(vec_count), 80'(0));
    check("t6a_err", 80'(err_count), 80'(0));

    // 6b: error counter saturation
    for (int k = 0; k < 260; k++) begin send(6, data_beat(k), 1'b0); exp_err(6, 3'd5); end
    check_events("t6b");
    check("t6b_err_sat", 80'(err_count), 80'(8'hFF));
    check("t6b_vec_all", 80'(vec_count), 80'(0));

    // 6c: reset at elem 6 with a beat held in the output register
    for (int i = 1; i <= 5; i++) pair(1, i, MARK, 1'b0);
    check_events("t6c_pre");
    m_tready = 1'b0;
    send(1, data_beat(6), 1'b0);
    @(negedge clk);
    check("t6c_held", 80'(m_tvalid), 80'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    got_ev.delete();
    @(negedge clk);
    check("t6c_discard", 80'(m_tvalid), 80'(0));
    check("t6c_err_rst", 80'(err_count), 80'(0));
    m_tready = 1'b1;
    @(posedge clk); #1;
    good_vec(1); exp_done(1);
    check_events("t6c");
    check("t6c_vec1", 80'(vc(1)), 80'(1));
    check("t6c_err", 80'(err_count), 80'(0));
    check("t6c_out_drained", 80'(exp_q.size()), 80'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
